// File: rtl/spi_pkg.sv
// spi_pkg
// Purpose : Definitions shared by the SPI slave front end and spi_ram.
//           Holds the 2-bit command encoding carried in din[9:8] and the
//           widths of the command word fields.
// Ports   : none (package)
package spi_pkg;

  localparam int CMD_W     = 2;
  localparam int PAYLOAD_W = 8;
  localparam int DIN_W     = CMD_W + PAYLOAD_W;

  typedef enum logic [CMD_W-1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

endpackage : spi_pkg

// File: rtl/spi_ram_if.sv
// spi_ram_if
// Purpose : Bundles the command/response signals exchanged between the SPI
//           slave and spi_ram.
// Signals : din      - command word, din[9:8] command, din[7:0] payload
//           rx_valid - din qualifier, one command per high cycle
//           dout     - read data returned to the SPI slave
//           tx_valid - dout qualifier
// Modports: master - SPI slave side (drives commands, receives read data)
//           slave  - spi_ram side (receives commands, drives read data)
interface spi_ram_if;
  import spi_pkg::*;

  logic [DIN_W-1:0]     din;
  logic                 rx_valid;
  logic [PAYLOAD_W-1:0] dout;
  logic                 tx_valid;

  modport master (output din, output rx_valid, input dout, input tx_valid);
  modport slave  (input din, input rx_valid, output dout, output tx_valid);

endinterface : spi_ram_if

// File: rtl/spi_ram_array.sv
// spi_ram_array
// Purpose : Storage for spi_ram. One synchronous write port and one
//           registered read port. Deliberately has no reset so that memory
//           contents survive a reset of the control logic.
// Ports   : clk   - clock
//           we    - write enable, waddr/wdata captured on rising edge
//           waddr - write address
//           wdata - write data
//           re    - read enable, rdata reloads from mem[raddr] on rising edge
//           raddr - read address
//           rdata - registered read data, holds while re is low
module spi_ram_array #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Read data only moves on an explicit read, so a later write to the same
  // address cannot disturb a value that is already being presented.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule : spi_ram_array

// File: rtl/spi_ram.sv
// spi_ram
// Purpose : Command-driven RAM behind an SPI slave. Decodes 10-bit command
//           words (write address, write data, read address, read data),
//           keeps independent write/read address registers and presents read
//           data with a valid flag that holds until the next command.
// Ports   : clk   - clock, all state changes on rising edge
//           rst_n - asynchronous active-low reset of control state
//                   (memory contents are kept)
//           bus   - spi_ram_if.slave: din, rx_valid in; dout, tx_valid out
module spi_ram
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  spi_ram_if.slave  bus
);

  cmd_e                 cmd;
  logic [PAYLOAD_W-1:0] payload;

  logic [ADDR_SIZE-1:0] waddr_d, waddr_q;
  logic [ADDR_SIZE-1:0] raddr_d, raddr_q;
  logic                 tx_valid_d, tx_valid_q;
  logic                 loaded_d, loaded_q;
  logic                 we, re;
  logic [PAYLOAD_W-1:0] rdata;

  assign cmd     = cmd_e'(bus.din[DIN_W-1:PAYLOAD_W]);
  assign payload = bus.din[PAYLOAD_W-1:0];

  // Any accepted command clears tx_valid; only RD_DATA sets it again.
  always_comb begin
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    tx_valid_d = tx_valid_q;
    loaded_d   = loaded_q;
    we         = 1'b0;
    re         = 1'b0;
    if (bus.rx_valid) begin
      tx_valid_d = 1'b0;
      case (cmd)
        WR_ADDR: waddr_d = payload[ADDR_SIZE-1:0];
        WR_DATA: we      = 1'b1;
        RD_ADDR: raddr_d = payload[ADDR_SIZE-1:0];
        RD_DATA: begin
          re         = 1'b1;
          tx_valid_d = 1'b1;
          loaded_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q    <= '0;
      raddr_q    <= '0;
      tx_valid_q <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      tx_valid_q <= tx_valid_d;
      loaded_q   <= loaded_d;
    end
  end

  // The array has no reset, so a command seen while rst_n is low must be
  // blocked here or it would still write memory on that edge.
  spi_ram_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_W    (PAYLOAD_W)
  ) u_array (
    .clk   (clk),
    .we    (we & rst_n),
    .waddr (waddr_q),
    .wdata (payload),
    .re    (re & rst_n),
    .raddr (raddr_q),
    .rdata (rdata)
  );

  // The array's read register cannot be reset, so dout is forced to zero
  // until the first read after reset has reloaded it.
  assign bus.dout     = loaded_q ? rdata : '0;
  assign bus.tx_valid = tx_valid_q;

endmodule : spi_ram
